frame_tx: RTL and testbench

FRAME_TX -- requirements
Module: frame_tx

---
 rtl/frame_tx.sv | 168 ++++++++++++++++
 tb/tb_frame_tx.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/frame_tx.sv
// Frame transmitter: on dv_in, snapshots the register file and streams it as one
// Ethernet frame (MAC header, sync, seq/count header, little-endian payload) over AXI-stream.
module frame_tx #(
  parameter int unsigned Nregs     = 16,
  parameter logic [47:0] DST_MAC   = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC   = 48'h00_0A_35_00_00_01,
  parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   dv_in,
  input  logic [Nregs-1:0][31:0] rd_val,
  output logic                   tx_fifo_tvalid,
  input  logic                   tx_fifo_tready,
  output logic [7:0]             tx_fifo_tdata,
  output logic                   tx_fifo_tlast,
  output logic                   tx_fifo_tuser,
  output logic                   busy,
  output logic [15:0]            drop_count
);
  localparam int unsigned   FRAME_LEN = 20 + 4 * Nregs;
  localparam int unsigned   CW        = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] LAST_IDX  = CW'(FRAME_LEN - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t                 state_r, state_next_s;
  logic [CW-1:0]          idx_r, idx_next_s, idx_inc_s;
  logic                   tvalid_r, tvalid_next_s;
  logic                   tlast_r, tlast_next_s;
  logic [7:0]             tdata_r, tdata_next_s;
  logic [Nregs-1:0][31:0] shadow_r;
  logic [15:0]            seq_r;
  logic [15:0]            drop_count_r;
  logic                   load_shadow_s, seq_inc_s, drop_inc_s;

  // Byte k of the frame for a given sequence number and register snapshot.
  function automatic logic [7:0] frame_byte(
    input logic [CW-1:0]          idx,
    input logic [15:0]            seq,
    input logic [Nregs-1:0][31:0] regs
  );
    logic [7:0]    b;
    logic [CW-1:0] p;
    logic [31:0]   word;
    b    = 8'h00;
    p    = idx - CW'(20);
    word = 32'h0000_0000;
    case (idx)
      CW'(0):  b = DST_MAC[47:40];
      CW'(1):  b = DST_MAC[39:32];
      CW'(2):  b = DST_MAC[31:24];
      CW'(3):  b = DST_MAC[23:16];
      CW'(4):  b = DST_MAC[15:8];
      CW'(5):  b = DST_MAC[7:0];
      CW'(6):  b = SRC_MAC[47:40];
      CW'(7):  b = SRC_MAC[39:32];
      CW'(8):  b = SRC_MAC[31:24];
      CW'(9):  b = SRC_MAC[23:16];
      CW'(10): b = SRC_MAC[15:8];
      CW'(11): b = SRC_MAC[7:0];
      CW'(12): b = ETHERTYPE[15:8];
      CW'(13): b = ETHERTYPE[7:0];
      CW'(14): b = 8'hF3;
      CW'(15): b = 8'hFA;
      CW'(16): b = seq[7:0];
      CW'(17): b = seq[15:8];
      CW'(18): b = 8'(Nregs);
      CW'(19): b = 8'h00;
      default: begin
        for (int i = 0; i < int'(Nregs); i++) begin
          if (p[CW-1:2] == (CW-2)'(i)) word = regs[i];
        end
        case (p[1:0])
          2'd0:    b = word[7:0];
          2'd1:    b = word[15:8];
          2'd2:    b = word[23:16];
          2'd3:    b = word[31:24];
          default: b = 8'h00;
        endcase
      end
    endcase
    return b;
  endfunction

  assign idx_inc_s = idx_r + CW'(1);

  // Next-state, next-byte and counter-enable decode.
  always_comb begin
    state_next_s  = state_r;
    idx_next_s    = idx_r;
    tvalid_next_s = tvalid_r;
    tlast_next_s  = tlast_r;
    tdata_next_s  = tdata_r;
    load_shadow_s = 1'b0;
    seq_inc_s     = 1'b0;
    drop_inc_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (dv_in) begin
          // Byte 0 is a MAC constant, so the not-yet-loaded shadow is never read here.
          state_next_s  = SEND;
          idx_next_s    = '0;
          tvalid_next_s = 1'b1;
          tlast_next_s  = 1'b0;
          tdata_next_s  = frame_byte('0, seq_r, shadow_r);
          load_shadow_s = 1'b1;
        end else begin
          tvalid_next_s = 1'b0;
          tlast_next_s  = 1'b0;
        end
      end
      SEND: begin
        drop_inc_s = dv_in;
        if (tvalid_r && tx_fifo_tready) begin
          if (tlast_r) begin
            state_next_s  = IDLE;
            idx_next_s    = '0;
            tvalid_next_s = 1'b0;
            tlast_next_s  = 1'b0;
            seq_inc_s     = 1'b1;
          end else begin
            idx_next_s   = idx_inc_s;
            tdata_next_s = frame_byte(idx_inc_s, seq_r, shadow_r);
            tlast_next_s = (idx_inc_s == LAST_IDX);
          end
        end else begin
          tvalid_next_s = 1'b1;
        end
      end
      default: begin
        state_next_s  = IDLE;
        tvalid_next_s = 1'b0;
        tlast_next_s  = 1'b0;
      end
    endcase
  end

  // State register, stream output registers and frame counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      idx_r        <= '0;
      tvalid_r     <= 1'b0;
      tlast_r      <= 1'b0;
      tdata_r      <= 8'h00;
      shadow_r     <= '0;
      seq_r        <= 16'h0000;
      drop_count_r <= 16'h0000;
    end else begin
      state_r  <= state_next_s;
      idx_r    <= idx_next_s;
      tvalid_r <= tvalid_next_s;
      tlast_r  <= tlast_next_s;
      tdata_r  <= tdata_next_s;
      if (load_shadow_s) shadow_r <= rd_val;
      if (seq_inc_s) seq_r <= seq_r + 16'd1;
      if (drop_inc_s && (drop_count_r != 16'hFFFF)) drop_count_r <= drop_count_r + 16'd1;
    end
  end

  assign tx_fifo_tvalid = tvalid_r;
  assign tx_fifo_tdata  = tdata_r;
  assign tx_fifo_tlast  = tlast_r;
  assign tx_fifo_tuser  = 1'b0;
  assign busy           = (state_r == SEND);
  assign drop_count     = drop_count_r;
endmodule

// File: tb/tb_frame_tx.sv
// Self-checking bench for frame_tx: directed frame scenarios with random data and
// back-pressure, compared byte-for-byte against a field-level frame model.
module tb_frame_tx;
  localparam int          NREGS = 16;
  localparam int          LEN   = 20 + 4 * NREGS;
  localparam logic [47:0] DST   = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] SRC   = 48'h00_0A_35_00_00_01;
  localparam logic [15:0] ETYPE = 16'h88B5;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   dv_in = 1'b0;
  logic [NREGS-1:0][31:0] rd_val = '0;
  logic                   tx_fifo_tvalid;
  logic                   tx_fifo_tready = 1'b0;
  logic [7:0]             tx_fifo_tdata;
  logic                   tx_fifo_tlast;
  logic                   tx_fifo_tuser;
  logic                   busy;
  logic [15:0]            drop_count;

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] model_seq = 16'h0000;
  logic [15:0] model_drop = 16'h0000;
  logic [7:0]  exp_q[$];

  frame_tx #(.Nregs(NREGS), .DST_MAC(DST), .SRC_MAC(SRC), .ETHERTYPE(ETYPE)) dut (
    .clk(clk), .reset(reset), .dv_in(dv_in), .rd_val(rd_val),
    .tx_fifo_tvalid(tx_fifo_tvalid), .tx_fifo_tready(tx_fifo_tready),
    .tx_fifo_tdata(tx_fifo_tdata), .tx_fifo_tlast(tx_fifo_tlast),
    .tx_fifo_tuser(tx_fifo_tuser), .busy(busy), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Expected frame assembled field by field from the register snapshot and seq number.
  function automatic void build_frame(input logic [NREGS-1:0][31:0] regs, input logic [15:0] seq);
    exp_q.delete();
    for (int k = 0; k < 6; k++) exp_q.push_back(8'(DST >> (8 * (5 - k))));
    for (int k = 0; k < 6; k++) exp_q.push_back(8'(SRC >> (8 * (5 - k))));
    exp_q.push_back(8'(ETYPE >> 8));
    exp_q.push_back(8'(ETYPE));
    exp_q.push_back(8'hF3);
    exp_q.push_back(8'hFA);
    exp_q.push_back(8'(seq));
    exp_q.push_back(8'(seq >> 8));
    exp_q.push_back(8'(NREGS));
    exp_q.push_back(8'h00);
    for (int i = 0; i < NREGS; i++)
      for (int j = 0; j < 4; j++) exp_q.push_back(8'(regs[i] >> (8 * j)));
  endfunction

  task automatic randomize_regs();
    for (int i = 0; i < NREGS; i++) rd_val[i] = $urandom();
  endtask

  // Launch one frame at the current data and follow it to its tlast handshake.
  task automatic run_frame(input string name, input int ready_pct, input bit mutate, input bit drops);
    int k = 0, cyc = 0, stall_bad = 0, gaps = 0, busy_bad = 0;
    bit done = 1'b0, prev_stall = 1'b0, prev_last = 1'b0;
    logic [7:0] prev_data = 8'h00;
    @(negedge clk);
    build_frame(rd_val, model_seq);
    dv_in = 1'b1;
    @(negedge clk);
    dv_in = 1'b0;
    check({name, "_latency_tvalid"}, 32'(tx_fifo_tvalid), 32'd1);
    while (!done && cyc < 8 * LEN) begin
      if (!tx_fifo_tvalid) gaps++;
      if (!busy) busy_bad++;
      if (prev_stall && (tx_fifo_tdata !== prev_data || tx_fifo_tlast !== prev_last)) stall_bad++;
      dv_in = 1'b0;
      tx_fifo_tready = ($urandom_range(99) < ready_pct);
      if (mutate) randomize_regs();
      if (drops && (cyc == 10 || cyc == 30 || cyc == 50)) begin
        dv_in = 1'b1;
        model_drop++;
      end
      if (tx_fifo_tvalid && tx_fifo_tready) begin
        check($sformatf("%s_byte%0d", name, k), 32'(tx_fifo_tdata), (k < LEN) ? 32'(exp_q[k]) : 32'hFFFF);
        check($sformatf("%s_tlast%0d", name, k), 32'(tx_fifo_tlast), 32'(k == LEN - 1));
        if (tx_fifo_tlast) begin
          done = 1'b1;
          if (drops && !dv_in) begin
            dv_in = 1'b1;
            model_drop++;
          end
        end
        k++;
      end
      prev_stall = tx_fifo_tvalid && !tx_fifo_tready;
      prev_data  = tx_fifo_tdata;
      prev_last  = tx_fifo_tlast;
      @(negedge clk);
      cyc++;
    end
    dv_in = 1'b0;
    check({name, "_completed"}, 32'(done), 32'd1);
    check({name, "_byte_count"}, 32'(k), 32'(LEN));
    check({name, "_stall_stability"}, 32'(stall_bad), 32'd0);
    check({name, "_tvalid_gaps"}, 32'(gaps), 32'd0);
    check({name, "_busy_in_frame"}, 32'(busy_bad), 32'd0);
    check({name, "_tvalid_after_last"}, 32'(tx_fifo_tvalid), 32'd0);
    check({name, "_busy_after_last"}, 32'(busy), 32'd0);
    check({name, "_drop_count"}, 32'(drop_count), 32'(model_drop));
    model_seq++;
  endtask

  initial begin
    int hs = 0, cyc = 0;
    tx_fifo_tready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_tvalid", 32'(tx_fifo_tvalid), 32'd0);
    check("reset_tlast", 32'(tx_fifo_tlast), 32'd0);
    check("reset_tdata", 32'(tx_fifo_tdata), 32'd0);
    check("reset_tuser", 32'(tx_fifo_tuser), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_drop_count", 32'(drop_count), 32'd0);

    // Ramp pattern, full throughput, then same data under 50% back-pressure.
    for (int i = 0; i < NREGS; i++) rd_val[i] = 32'h0101_0101 * i;
    run_frame("ramp", 100, 1'b0, 1'b0);
    run_frame("ramp_bp", 50, 1'b0, 1'b0);
    // Rejected dv_in pulses, including one on the tlast handshake.
    randomize_regs();
    run_frame("drops", 100, 1'b0, 1'b1);
    // Register file churning during transmission.
    randomize_regs();
    run_frame("mutate", 50, 1'b1, 1'b0);

    // Sequence number wrap.
    @(negedge clk);
    force dut.seq_r = 16'hFFFF;
    @(negedge clk);
    release dut.seq_r;
    model_seq = 16'hFFFF;
    randomize_regs();
    run_frame("seq_ffff", 100, 1'b0, 1'b0);
    randomize_regs();
    run_frame("seq_wrap", 70, 1'b0, 1'b0);

    // Reset at byte 40, with a dv_in pulse during the reset cycle.
    @(negedge clk);
    randomize_regs();
    dv_in = 1'b1;
    tx_fifo_tready = 1'b1;
    @(negedge clk);
    dv_in = 1'b0;
    while (hs < 40 && cyc < 4 * LEN) begin
      if (tx_fifo_tvalid) hs++;
      @(negedge clk);
      cyc++;
    end
    check("abort_reached_byte40", 32'(hs), 32'd40);
    reset = 1'b1;
    dv_in = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    dv_in = 1'b0;
    check("abort_tvalid", 32'(tx_fifo_tvalid), 32'd0);
    check("abort_tlast", 32'(tx_fifo_tlast), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_drop_count", 32'(drop_count), 32'd0);
    @(negedge clk);
    check("abort_dv_ignored", 32'(tx_fifo_tvalid), 32'd0);
    model_seq  = 16'h0000;
    model_drop = 16'h0000;
    randomize_regs();
    run_frame("post_reset", 60, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
